// File: rtl/serv_seq.sv
// serv_seq: instruction-phase sequencer for the SERV core with a datapath of
// W bits per cycle (W = 1, 2, 4 or 8). A pass over a 32-bit operand takes
// 32/W cycles. The sequencer owns the phase state machine (fetch, register-file
// wait, stage-one pass, memory/MDU wait, execute pass), the bit counter and its
// decoded strobes, and the valid/ready handshake to an optional MDU.
//
// Parameters:
//   W        bits per cycle (1, 2, 4, 8)
//   WITH_CSR 1 enables trap generation, 0 forces trap outputs low
//   ALIGN    1 suppresses misaligned jump/branch traps
//
// Build option:
//   SERV_SEQ_MDU_EN  when defined the MDU handshake (o_mdu_valid/i_mdu_ready,
//                    i_mdu_op) is active; when undefined o_mdu_valid is 0 and
//                    i_mdu_op/i_mdu_ready are ignored.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_ibus_ack/o_ibus_cyc  instruction fetch handshake
//   i_rf_ready             register file ready for a pass
//   o_rf_rreq/o_rf_wreq    register file read/write request pulses
//   i_two_stage_op .. i_mdu_op  decoder controls
//   i_alu_cmp              ALU compare result
//   i_ctrl_misalign        jump target misaligned
//   i_mem_misalign         data address misaligned
//   i_new_irq              interrupt pending
//   o_dbus_cyc/i_dbus_ack  data bus handshake
//   o_mdu_valid/i_mdu_ready MDU handshake
//   o_cnt, o_cnt_en        beat index (lowest bit of beat) and pass-active
//   o_cnt0..o_cnt12        current beat covers that bit
//   o_cnt_done             last beat of a pass
//   o_mem_bytecnt          o_cnt[4:3]
//   o_init                 stage-one pass active
//   o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap  control unit strobes
//   o_state                FSM state, debug only
module serv_seq #(
  parameter int unsigned W        = 1,
  parameter int unsigned WITH_CSR = 1,
  parameter int unsigned ALIGN    = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  // instruction bus
  input  logic       i_ibus_ack,
  output logic       o_ibus_cyc,
  // register file
  input  logic       i_rf_ready,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  // decoder
  input  logic       i_two_stage_op,
  input  logic       i_branch_op,
  input  logic       i_cond_branch,
  input  logic       i_bne_or_bge,
  input  logic       i_shift_op,
  input  logic       i_sh_done,
  input  logic       i_slt_or_branch,
  input  logic       i_dbus_en,
  input  logic       i_e_op,
  input  logic       i_mdu_op,
  // datapath status
  input  logic       i_alu_cmp,
  input  logic       i_ctrl_misalign,
  input  logic       i_mem_misalign,
  input  logic       i_new_irq,
  // data bus
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  // MDU
  output logic       o_mdu_valid,
  input  logic       i_mdu_ready,
  // counter
  output logic [4:0] o_cnt,
  output logic       o_cnt_en,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_cnt2,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_cnt11,
  output logic       o_cnt12,
  output logic       o_cnt_done,
  output logic [1:0] o_mem_bytecnt,
  // control
  output logic       o_init,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic [2:0] o_state
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 5;

  localparam logic [STATE_W-1:0] FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] RFWAIT = 3'd1;
  localparam logic [STATE_W-1:0] INIT   = 3'd2;
  localparam logic [STATE_W-1:0] WAIT   = 3'd3;
  localparam logic [STATE_W-1:0] EXEC   = 3'd4;

  // Counter step, and the index of the last beat. Because W is a power of two
  // the last-beat index doubles as the mask that clears the in-beat bits.
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(32 - W);

  localparam logic CSR_EN   = (WITH_CSR != 0);
  localparam logic ALIGN_EN = (ALIGN != 0);

  logic [STATE_W-1:0] state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               stage2, stage2_nxt;
  logic               jump_r, jump_nxt;
  logic               trap_r, trap_nxt;

  logic pass_active;
  logic cnt_done;
  logic take_branch;
  logic trap_cond;
  logic wait_wreq;
  logic mdu_op_c;
  logic mdu_ready_c;

  // MDU handshake inputs, gated by the build option
`ifdef SERV_SEQ_MDU_EN
  assign mdu_op_c    = i_mdu_op;
  assign mdu_ready_c = i_mdu_ready;
`else
  logic unused_mdu;
  assign mdu_op_c    = 1'b0;
  assign mdu_ready_c = 1'b0;
  assign unused_mdu  = &{1'b0, i_mdu_op, i_mdu_ready};
`endif

  // Beat k is covered when the beat base equals k with its in-beat bits cleared
  function automatic logic beat_has(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] k);
    beat_has = (c == (k & CNT_LAST));
  endfunction

  // Pass bookkeeping and decoded counter strobes
  assign pass_active = (state == INIT) || (state == EXEC);
  assign cnt_done    = pass_active && (cnt == CNT_LAST);

  assign o_cnt         = cnt;
  assign o_cnt_en      = pass_active;
  assign o_cnt_done    = cnt_done;
  assign o_cnt0        = pass_active & beat_has(cnt, 5'd0);
  assign o_cnt1        = pass_active & beat_has(cnt, 5'd1);
  assign o_cnt2        = pass_active & beat_has(cnt, 5'd2);
  assign o_cnt3        = pass_active & beat_has(cnt, 5'd3);
  assign o_cnt7        = pass_active & beat_has(cnt, 5'd7);
  assign o_cnt11       = pass_active & beat_has(cnt, 5'd11);
  assign o_cnt12       = pass_active & beat_has(cnt, 5'd12);
  assign o_mem_bytecnt = cnt[4:3];
  assign o_state       = state;

  // Branch decision and stage-one trap causes, sampled on the INIT done beat
  assign take_branch = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
  assign trap_cond   = CSR_EN & ((take_branch & i_ctrl_misalign & ~ALIGN_EN) |
                                 (i_dbus_en & i_mem_misalign));

  // Any of these completes the WAIT phase; several at once still give one pulse
  assign wait_wreq = i_dbus_ack | (i_shift_op & i_sh_done) | i_slt_or_branch |
                     (mdu_op_c & mdu_ready_c);

  // State and bookkeeping registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= FETCH;
      cnt    <= '0;
      stage2 <= 1'b0;
      jump_r <= 1'b0;
      trap_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stage2 <= stage2_nxt;
      jump_r <= jump_nxt;
      trap_r <= trap_nxt;
    end
  end

  // Next-state and phase outputs
  always_comb begin
    state_nxt    = state;
    stage2_nxt   = stage2;
    jump_nxt     = jump_r;
    trap_nxt     = trap_r;
    o_ibus_cyc   = 1'b0;
    o_rf_rreq    = 1'b0;
    o_rf_wreq    = 1'b0;
    o_init       = 1'b0;
    o_ctrl_pc_en = 1'b0;
    o_ctrl_jump  = 1'b0;
    o_ctrl_trap  = 1'b0;
    o_dbus_cyc   = 1'b0;
    o_mdu_valid  = 1'b0;

    unique case (state)
      FETCH: begin
        o_ibus_cyc = 1'b1;
        if (i_ibus_ack) begin
          o_rf_rreq  = 1'b1;
          stage2_nxt = 1'b0;
          trap_nxt   = 1'b0;
          state_nxt  = RFWAIT;
        end
      end

      RFWAIT: begin
        if (i_rf_ready) begin
          // An interrupt skips stage one and traps straight from EXEC
          if (!stage2 && i_two_stage_op && !i_new_irq) begin
            state_nxt = INIT;
          end else begin
            state_nxt = EXEC;
          end
        end
      end

      INIT: begin
        o_init = 1'b1;
        if (cnt_done) begin
          jump_nxt  = take_branch;
          trap_nxt  = trap_r | trap_cond;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        o_dbus_cyc  = i_dbus_en & ~trap_r;
        o_mdu_valid = mdu_op_c & ~trap_r;
        // A pending trap re-reads the register file for the trap handler
        // instead of waiting on the bus or MDU; it leaves after one cycle.
        if (trap_r) begin
          o_rf_rreq  = 1'b1;
          stage2_nxt = 1'b1;
          state_nxt  = RFWAIT;
        end else if (wait_wreq) begin
          o_rf_wreq  = 1'b1;
          stage2_nxt = 1'b1;
          state_nxt  = RFWAIT;
        end
      end

      EXEC: begin
        o_ctrl_pc_en = 1'b1;
        o_ctrl_jump  = jump_r;
        o_ctrl_trap  = CSR_EN & (i_e_op | i_new_irq | trap_r);
        if (cnt_done) begin
          jump_nxt  = 1'b0;
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Counter advances only during a pass and wraps to 0 after the last beat
  always_comb begin
    cnt_nxt = cnt;
    if (pass_active) begin
      cnt_nxt = cnt + CNT_STEP;
    end
  end

endmodule

// File: tb/tb_serv_seq.sv
// Self-checking bench for serv_seq at W=4. Expected beat indices for each pass
// are queued when i_rf_ready is driven and popped as the DUT produces beats.
module tb_serv_seq;

  localparam int unsigned W     = 4;
  localparam int unsigned BEATS = 32 / W;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_RFWAIT = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;

  logic       clk;
  logic       rst;
  logic       i_ibus_ack, i_rf_ready;
  logic       i_two_stage_op, i_branch_op, i_cond_branch, i_bne_or_bge;
  logic       i_shift_op, i_sh_done, i_slt_or_branch, i_dbus_en, i_e_op, i_mdu_op;
  logic       i_alu_cmp, i_ctrl_misalign, i_mem_misalign, i_new_irq;
  logic       i_dbus_ack, i_mdu_ready;
  logic       o_ibus_cyc, o_rf_rreq, o_rf_wreq, o_dbus_cyc, o_mdu_valid;
  logic [4:0] o_cnt;
  logic       o_cnt_en, o_cnt0, o_cnt1, o_cnt2, o_cnt3, o_cnt7, o_cnt11, o_cnt12;
  logic       o_cnt_done, o_init, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap;
  logic [1:0] o_mem_bytecnt;
  logic [2:0] o_state;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  serv_seq #(.W(W), .WITH_CSR(1), .ALIGN(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_ack(i_ibus_ack), .o_ibus_cyc(o_ibus_cyc),
    .i_rf_ready(i_rf_ready), .o_rf_rreq(o_rf_rreq), .o_rf_wreq(o_rf_wreq),
    .i_two_stage_op(i_two_stage_op), .i_branch_op(i_branch_op),
    .i_cond_branch(i_cond_branch), .i_bne_or_bge(i_bne_or_bge),
    .i_shift_op(i_shift_op), .i_sh_done(i_sh_done),
    .i_slt_or_branch(i_slt_or_branch), .i_dbus_en(i_dbus_en),
    .i_e_op(i_e_op), .i_mdu_op(i_mdu_op),
    .i_alu_cmp(i_alu_cmp), .i_ctrl_misalign(i_ctrl_misalign),
    .i_mem_misalign(i_mem_misalign), .i_new_irq(i_new_irq),
    .o_dbus_cyc(o_dbus_cyc), .i_dbus_ack(i_dbus_ack),
    .o_mdu_valid(o_mdu_valid), .i_mdu_ready(i_mdu_ready),
    .o_cnt(o_cnt), .o_cnt_en(o_cnt_en),
    .o_cnt0(o_cnt0), .o_cnt1(o_cnt1), .o_cnt2(o_cnt2), .o_cnt3(o_cnt3),
    .o_cnt7(o_cnt7), .o_cnt11(o_cnt11), .o_cnt12(o_cnt12),
    .o_cnt_done(o_cnt_done), .o_mem_bytecnt(o_mem_bytecnt),
    .o_init(o_init), .o_ctrl_pc_en(o_ctrl_pc_en),
    .o_ctrl_jump(o_ctrl_jump), .o_ctrl_trap(o_ctrl_trap),
    .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic covers(input int c, input int k);
    return (c <= k) && (k < c + int'(W));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_ctrl();
    i_two_stage_op = 0; i_branch_op = 0; i_cond_branch = 0; i_bne_or_bge = 0;
    i_shift_op = 0; i_sh_done = 0; i_slt_or_branch = 0; i_dbus_en = 0;
    i_e_op = 0; i_mdu_op = 0; i_alu_cmp = 0; i_ctrl_misalign = 0;
    i_mem_misalign = 0; i_new_irq = 0; i_dbus_ack = 0; i_mdu_ready = 0;
    i_ibus_ack = 0; i_rf_ready = 0;
  endtask

  // Issue a fetch acknowledge from FETCH and land in RFWAIT
  task automatic fetch_instr(input string name);
    i_ibus_ack = 1;
    settle();
    checks++;
    if ({o_state, o_ibus_cyc, o_rf_rreq} !== {S_FETCH, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL %s fetch: state=%0d cyc=%b rreq=%b, want state=0 cyc=1 rreq=1",
               name, o_state, o_ibus_cyc, o_rf_rreq);
    end
    tick();
    i_ibus_ack = 0;
    settle();
    checks++;
    if ({o_state, o_ibus_cyc, o_rf_rreq} !== {S_RFWAIT, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s rfwait: state=%0d cyc=%b rreq=%b, want state=1 cyc=0 rreq=0",
               name, o_state, o_ibus_cyc, o_rf_rreq);
    end
  endtask

  // From RFWAIT: drive i_rf_ready, then check every beat of the pass
  task automatic do_pass(input string name, input logic exp_init,
                         input logic exp_jump, input logic exp_trap);
    int c;
    logic [18:0] obs, exp_v;
    logic [4:0] c5;
    i_rf_ready = 1;
    for (int k = 0; k < 32; k += int'(W)) exp_q.push_back(k);
    tick();
    i_rf_ready = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      c5 = 5'(c);
      settle();
      obs   = {o_cnt, o_cnt_en, o_init, o_cnt_done, o_cnt0, o_cnt3, o_cnt12,
               o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_mem_bytecnt, o_state};
      exp_v = {c5, 1'b1, exp_init, 1'(c == 32 - int'(W)), covers(c, 0),
               covers(c, 3), covers(c, 12), ~exp_init,
               exp_init ? 1'b0 : exp_jump, exp_init ? 1'b0 : exp_trap,
               c5[4:3], exp_init ? S_INIT : S_EXEC};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s beat cnt=%0d: got %b want %b", name, c, obs, exp_v);
      end
      tick();
    end
    settle();
    checks++;
    if (exp_init) begin
      if ({o_state, o_cnt_en, o_cnt} !== {S_WAIT, 1'b0, 5'd0}) begin
        errors++;
        $display("FAIL %s after init: state=%0d en=%b cnt=%0d, want 3 0 0",
                 name, o_state, o_cnt_en, o_cnt);
      end
    end else begin
      if ({o_state, o_ibus_cyc, o_cnt_en, o_cnt} !== {S_FETCH, 1'b1, 1'b0, 5'd0}) begin
        errors++;
        $display("FAIL %s after exec: state=%0d cyc=%b en=%b cnt=%0d, want 0 1 0 0",
                 name, o_state, o_ibus_cyc, o_cnt_en, o_cnt);
      end
    end
  endtask

  task automatic test_reset();
    clear_ctrl();
    rst = 1;
    tick();
    tick();
    settle();
    checks++;
    if ({o_state, o_ibus_cyc, o_cnt, o_cnt_en, o_rf_rreq, o_rf_wreq, o_dbus_cyc,
         o_mdu_valid, o_init, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_cnt_done,
         o_cnt0} !== {S_FETCH, 1'b1, 5'd0, 11'd0}) begin
      errors++;
      $display("FAIL reset values: state=%0d cyc=%b cnt=%0d en=%b", o_state,
               o_ibus_cyc, o_cnt, o_cnt_en);
    end
    rst = 0;
    tick();
    settle();
    checks++;
    if ({o_state, o_ibus_cyc} !== {S_FETCH, 1'b1}) begin
      errors++;
      $display("FAIL after reset: state=%0d cyc=%b, want 0 1", o_state, o_ibus_cyc);
    end
  endtask

  task automatic test_single_stage();
    clear_ctrl();
    fetch_instr("single");
    do_pass("single", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    clear_ctrl();
    i_two_stage_op = 1; i_branch_op = 1; i_cond_branch = 1;
    i_alu_cmp = 1; i_slt_or_branch = 1;
    fetch_instr("beq");
    do_pass("beq init", 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_rf_wreq, o_rf_rreq, o_dbus_cyc} !== 3'b100) begin
      errors++;
      $display("FAIL beq wait: wreq=%b rreq=%b dbus=%b, want 1 0 0",
               o_rf_wreq, o_rf_rreq, o_dbus_cyc);
    end
    tick();
    settle();
    checks++;
    if ({o_state, o_rf_wreq} !== {S_RFWAIT, 1'b0}) begin
      errors++;
      $display("FAIL beq stage2: state=%0d wreq=%b, want 1 0", o_state, o_rf_wreq);
    end
    do_pass("beq exec", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_misalign_load();
    clear_ctrl();
    i_two_stage_op = 1; i_dbus_en = 1; i_mem_misalign = 1;
    fetch_instr("misld");
    do_pass("misld init", 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_dbus_cyc, o_rf_rreq, o_rf_wreq} !== 3'b010) begin
      errors++;
      $display("FAIL misld wait: dbus=%b rreq=%b wreq=%b, want 0 1 0",
               o_dbus_cyc, o_rf_rreq, o_rf_wreq);
    end
    tick();
    settle();
    checks++;
    if ({o_state, o_rf_rreq, o_dbus_cyc} !== {S_RFWAIT, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL misld rfwait: state=%0d rreq=%b dbus=%b, want 1 0 0",
               o_state, o_rf_rreq, o_dbus_cyc);
    end
    do_pass("misld exec", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_store();
    clear_ctrl();
    i_two_stage_op = 1; i_dbus_en = 1;
    fetch_instr("store");
    do_pass("store init", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_state, o_dbus_cyc, o_rf_wreq} !== {S_WAIT, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL store wait%0d: state=%0d dbus=%b wreq=%b, want 3 1 0",
                 i, o_state, o_dbus_cyc, o_rf_wreq);
      end
      tick();
      settle();
    end
    i_dbus_ack = 1;
    settle();
    checks++;
    if ({o_dbus_cyc, o_rf_wreq} !== 2'b11) begin
      errors++;
      $display("FAIL store ack: dbus=%b wreq=%b, want 1 1", o_dbus_cyc, o_rf_wreq);
    end
    tick();
    i_dbus_ack = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({o_state, o_dbus_cyc, o_rf_wreq} !== {S_RFWAIT, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL store idle%0d: state=%0d dbus=%b wreq=%b, want 1 0 0",
                 i, o_state, o_dbus_cyc, o_rf_wreq);
      end
      tick();
    end
    do_pass("store exec", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mdu();
    clear_ctrl();
    i_two_stage_op = 1; i_mdu_op = 1;
`ifndef SERV_SEQ_MDU_EN
    i_dbus_en = 1;
    i_mdu_ready = 1;
`endif
    fetch_instr("mdu");
    do_pass("mdu init", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
`ifdef SERV_SEQ_MDU_EN
      if ({o_state, o_mdu_valid, o_rf_wreq} !== {S_WAIT, 1'b1, 1'b0}) begin
`else
      if ({o_state, o_mdu_valid, o_rf_wreq} !== {S_WAIT, 1'b0, 1'b0}) begin
`endif
        errors++;
        $display("FAIL mdu wait%0d: state=%0d valid=%b wreq=%b", i, o_state,
                 o_mdu_valid, o_rf_wreq);
      end
      tick();
      settle();
    end
    // Completion and data ack together must still give one pulse
    i_mdu_ready = 1;
    i_dbus_ack  = 1;
    settle();
    checks++;
    if (o_rf_wreq !== 1'b1) begin
      errors++;
      $display("FAIL mdu done: wreq=%b, want 1", o_rf_wreq);
    end
    tick();
    settle();
    checks++;
    if ({o_state, o_rf_wreq, o_mdu_valid} !== {S_RFWAIT, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mdu single pulse: state=%0d wreq=%b valid=%b, want 1 0 0",
               o_state, o_rf_wreq, o_mdu_valid);
    end
    i_mdu_ready = 0;
    i_dbus_ack  = 0;
    do_pass("mdu exec", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    clear_ctrl();
    i_rf_ready = 1;
    tick();
    settle();
    checks++;
    if ({o_state, o_cnt_en} !== {S_FETCH, 1'b0}) begin
      errors++;
      $display("FAIL rf_ready in fetch: state=%0d en=%b, want 0 0", o_state, o_cnt_en);
    end
    i_rf_ready = 0;
    i_ibus_ack = 1;
    tick();
    settle();
    checks++;
    if ({o_state, o_rf_rreq} !== {S_RFWAIT, 1'b0}) begin
      errors++;
      $display("FAIL ibus_ack in rfwait: state=%0d rreq=%b, want 1 0", o_state, o_rf_rreq);
    end
    i_ibus_ack = 0;
    do_pass("ign exec", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_ctrl();
    i_two_stage_op = 1; i_new_irq = 1;
    fetch_instr("irq");
    do_pass("irq exec", 1'b0, 1'b0, 1'b1);
    clear_ctrl();
    fetch_instr("b2b");
    do_pass("b2b exec", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    clear_ctrl();
    i_two_stage_op = 1;
    fetch_instr("rstmid");
    i_rf_ready = 1;
    tick();
    i_rf_ready = 0;
    for (int i = 0; i < int'(BEATS) && !found; i++) begin
      settle();
      if (o_state == S_INIT && o_cnt == 5'd12) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid reach: cnt=12 in INIT not seen, state=%0d cnt=%0d",
               o_state, o_cnt);
    end
    rst = 1;
    #1;
    checks++;
    if ({o_state, o_cnt, o_ibus_cyc, o_cnt_en, o_init} !== {S_FETCH, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid async: state=%0d cnt=%0d cyc=%b en=%b init=%b",
               o_state, o_cnt, o_ibus_cyc, o_cnt_en, o_init);
    end
    tick();
    rst = 0;
    tick();
    settle();
    checks++;
    if ({o_state, o_cnt, o_ibus_cyc} !== {S_FETCH, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid release: state=%0d cnt=%0d cyc=%b", o_state, o_cnt, o_ibus_cyc);
    end
    tick();
  endtask

  initial begin
    rst = 1;
    clear_ctrl();
    test_reset();
    test_single_stage();
    test_branch();
    test_misalign_load();
    test_store();
    test_mdu();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
